// File: rtl/hs_elastic_fifo.sv
// hs_elastic_fifo: multi-entry valid/ready FIFO with registered forward and backward paths.
// in_ready/out_valid decode only from the occupancy register, so out_ready never reaches in_ready.
module hs_elastic_fifo #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
    input  logic                       clk_core,
    input  logic                       rst_core_n,
    input  logic                       flush_req,
    output logic                       stall,
    input  logic [WIDTH-1:0]           in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       almost_full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push, pop;

    assign in_ready    = (count_q != CW'(DEPTH));
    assign out_valid   = (count_q != '0);
    assign stall       = ~in_ready;
    assign level       = count_q;
    assign almost_full = (count_q >= CW'(AFULL_LEVEL));
    assign out         = mem_q[rd_ptr_q];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Explicit wrap keeps non-power-of-two depths inside the storage range.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_req) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_core) begin
        if (push && !flush_req) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

    assert property (@(posedge clk_core) disable iff (!rst_core_n)
        count_q <= CW'(DEPTH));
    assert property (@(posedge clk_core) disable iff (!rst_core_n)
        (count_q == CW'(DEPTH) || count_q == '0) |-> (wr_ptr_q == rd_ptr_q));

endmodule

// File: tb/tb_hs_elastic_fifo.sv
// Bench for hs_elastic_fifo: lane 0 is DEPTH=4/AFULL=3, lane 1 is DEPTH=3/AFULL=2.
// A queue-based reference model records accepted beats; a per-lane monitor checks flags and data.
module tb_hs_elastic_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din   [2];
  logic       vin   [2];
  logic       ordy  [2];
  logic       flush [2];
  logic       fin   [2];

  int cmp_count = 0;
  int err_count = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned D  = (g == 0) ? 4 : 3;
    localparam int unsigned AF = (g == 0) ? 3 : 2;
    localparam int unsigned LW = $clog2(D + 1);

    logic [7:0]    dout;
    logic          ov, ir, st, af;
    logic [LW-1:0] lvl;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cnt = 0;
    bit         fin_done = 1'b0;
    logic [7:0] exp_q [$];

    hs_elastic_fifo #(.WIDTH(8), .DEPTH(D), .AFULL_LEVEL(AF)) dut (
      .clk_core   (clk),
      .rst_core_n (rst_n),
      .flush_req  (flush[g]),
      .stall      (st),
      .in         (din[g]),
      .in_valid   (vin[g]),
      .in_ready   (ir),
      .out        (dout),
      .out_valid  (ov),
      .out_ready  (ordy[g]),
      .level      (lvl),
      .almost_full(af)
    );

    function automatic void chk(string name, int act, int exp);
      n_cmp++;
      cmp_count++;
      if (act != exp) begin
        n_err++;
        err_count++;
        $display("FAIL lane%0d %s: got 0x%0h expected 0x%0h at %0t", g, name, act, exp, $time);
      end
    endfunction

    // Reference model: occupancy from the handshake rules; accepted beats enter the queue.
    initial forever begin
      bit push, pop;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cnt = 0;
        exp_q.delete();
      end else begin
        push = vin[g] && (cnt != int'(D));
        pop  = (cnt != 0) && ordy[g];
        if (flush[g]) begin
          cnt = 0;
          exp_q.delete();
        end else begin
          if (push) exp_q.push_back(din[g]);
          cnt = cnt + int'(push) - int'(pop);
        end
      end
    end

    // Monitor: flags against model occupancy, head data against the queue.
    initial forever begin
      @(negedge clk);
      chk("out_valid", int'(ov), int'(cnt != 0));
      chk("in_ready", int'(ir), int'(cnt != int'(D)));
      chk("stall", int'(st), int'(cnt == int'(D)));
      chk("level", int'(lvl), cnt);
      chk("almost_full", int'(af), int'(cnt >= int'(AF)));
      chk("ptr_range", int'(int'(dut.rd_ptr_q) < int'(D) && int'(dut.wr_ptr_q) < int'(D)), 1);
      if (ov && ordy[g]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", int'(dout), -1);
        end else begin
          chk("data", int'(dout), int'(exp_q.pop_front()));
        end
      end
      if (fin[g] && !fin_done) begin
        fin_done = 1'b1;
        chk("leftover_beats", exp_q.size(), 0);
      end
    end
  end

  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(int g, bit v, logic [7:0] d, bit r, bit f);
    vin[g]   = v;
    din[g]   = d;
    ordy[g]  = r;
    flush[g] = f;
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      drive(g, 1'b0, 8'h00, 1'b0, 1'b0);
      fin[g] = 1'b0;
    end
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(5);

    // Fill lane 0 to full, hold a fifth beat off, then drain through the full+pop corner.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
      step();
    end
    drive(0, 1'b1, 8'hA5, 1'b0, 1'b0);
    step(3);
    drive(0, 1'b1, 8'hA5, 1'b1, 1'b0);
    step(2);
    drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(6);

    // Streaming at full rate.
    for (int i = 0; i < 100; i++) begin
      drive(0, 1'b1, 8'(i), 1'b1, 1'b0);
      step();
    end
    drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(3);

    // Flush with level 3, coincident push of 0xFF and pop.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
      step();
    end
    drive(0, 1'b1, 8'hFF, 1'b1, 1'b1);
    step();
    drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(4);

    // Random traffic on lane 0 with occasional flush.
    for (int i = 0; i < 300; i++) begin
      drive(0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
      step();
    end
    drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(6);

    // Non-power-of-two lane: 1000 random cycles.
    for (int i = 0; i < 1000; i++) begin
      drive(1, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)),
            $urandom_range(0, 1) == 1, 1'b0);
      step();
    end
    drive(1, 1'b0, 8'h00, 1'b1, 1'b0);
    step(6);

    fin[0] = 1'b1;
    fin[1] = 1'b1;
    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
